// File: rtl/sprite_compositor.sv
// Three-stage sprite layer: address generation, ROM wait, then priority compositing.
// Also accumulates per-frame pixel-exact collisions between sprite 0 and every other sprite.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          COORD_W     = 10,
    parameter int          SPRITE_DIM  = 26,
    parameter int          NUM_FRAMES  = 4,
    parameter int          ADDR_W      = 12,
    parameter int          PLAYFIELD_W = 405,
    parameter logic [23:0] TRANSPARENT = 24'h000000
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            pix_en,
    input  logic [COORD_W-1:0]              DrawX,
    input  logic [COORD_W-1:0]              DrawY,
    input  logic                            blank,
    input  logic                            frame_start,
    input  logic [23:0]                     bg_rgb,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0]  spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]  spr_y,
    input  logic [NUM_SPRITES*2-1:0]        spr_frame,
    output logic [NUM_SPRITES*ADDR_W-1:0]   rom_addr,
    output logic                            rom_rd,
    input  logic [NUM_SPRITES*24-1:0]       rom_data,
    output logic [7:0]                      Red,
    output logic [7:0]                      Green,
    output logic [7:0]                      Blue,
    output logic                            out_valid,
    output logic [NUM_SPRITES-2:0]          collision,
    output logic                            coll_valid
);

    localparam logic [COORD_W-1:0] DIM_C     = COORD_W'(SPRITE_DIM);
    localparam logic [COORD_W-1:0] PF_C      = COORD_W'(PLAYFIELD_W);
    localparam logic [ADDR_W-1:0]  DIM_A     = ADDR_W'(SPRITE_DIM);
    localparam logic [ADDR_W-1:0]  AREA_A    = ADDR_W'(SPRITE_DIM * SPRITE_DIM);
    localparam logic [ADDR_W-1:0]  LAST_FR_A = ADDR_W'(NUM_FRAMES - 1);

    // S1 combinational
    logic [NUM_SPRITES-1:0]        hit_d;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_d;
    logic                          off_d;

    // Stage registers
    logic [NUM_SPRITES-1:0]        hit1_q, hit2_q;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_q;
    logic                          blank1_q, blank2_q;
    logic                          off1_q, off2_q;
    logic [23:0]                   bg1_q, bg2_q;
    logic                          v1_q, v2_q, out_valid_q;

    // S3
    logic [NUM_SPRITES-1:0]        opaque;
    logic [23:0]                   sel_rgb;
    logic [23:0]                   rgb_d, rgb_q;
    logic [NUM_SPRITES-2:0]        det;

    // Collision
    logic [NUM_SPRITES-2:0]        acc_d, acc_q;
    logic [NUM_SPRITES-2:0]        coll_d, coll_q;
    logic                          coll_valid_d, coll_valid_q;

    assign off_d = (DrawX >= PF_C);

    // Offsets are one bit wider than the coordinates so a sprite left of or above
    // the pixel shows up as negative instead of wrapping into range.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_s1
            logic [COORD_W:0] dx;
            logic [COORD_W:0] dy;
            logic [ADDR_W-1:0] fr_ext;
            logic [ADDR_W-1:0] fr_sel;
            logic [ADDR_W-1:0] offs;

            assign dx     = {1'b0, DrawX} - {1'b0, spr_x[gi*COORD_W +: COORD_W]};
            assign dy     = {1'b0, DrawY} - {1'b0, spr_y[gi*COORD_W +: COORD_W]};
            assign fr_ext = ADDR_W'(spr_frame[gi*2 +: 2]);
            assign fr_sel = (fr_ext > LAST_FR_A) ? LAST_FR_A : fr_ext;

            assign hit_d[gi] = spr_en[gi]
                             & ~dx[COORD_W] & (dx[COORD_W-1:0] < DIM_C)
                             & ~dy[COORD_W] & (dy[COORD_W-1:0] < DIM_C);

            assign offs = fr_sel * AREA_A
                        + ADDR_W'(dy[COORD_W-1:0]) * DIM_A
                        + ADDR_W'(dx[COORD_W-1:0]);

            assign addr_d[gi*ADDR_W +: ADDR_W] = hit_d[gi] ? offs : '0;
        end

        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_opaque
            assign opaque[gi] = hit2_q[gi] & (rom_data[gi*24 +: 24] != TRANSPARENT);
        end

        // Stacked sprites still collide: detection uses opacity, not visibility.
        for (gi = 1; gi < NUM_SPRITES; gi++) begin : g_det
            assign det[gi-1] = opaque[0] & opaque[gi] & blank2_q;
        end
    endgenerate

    // Lowest opaque index wins; walk from the highest index down so it overrides.
    always_comb begin
        sel_rgb = bg2_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel_rgb = rom_data[i*24 +: 24];
            end
        end
        rgb_d = (blank2_q && !off2_q) ? sel_rgb : 24'h000000;
    end

    always_comb begin
        acc_d        = acc_q;
        coll_d       = coll_q;
        coll_valid_d = 1'b0;
        if (pix_en) begin
            if (frame_start) begin
                coll_d       = acc_q | det;
                acc_d        = '0;
                coll_valid_d = 1'b1;
            end else begin
                acc_d = acc_q | det;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit1_q       <= '0;
            hit2_q       <= '0;
            addr_q       <= '0;
            blank1_q     <= 1'b0;
            blank2_q     <= 1'b0;
            off1_q       <= 1'b0;
            off2_q       <= 1'b0;
            bg1_q        <= '0;
            bg2_q        <= '0;
            rgb_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            coll_q       <= coll_d;
            coll_valid_q <= coll_valid_d;
            out_valid_q  <= pix_en & v2_q;
            if (pix_en) begin
                hit1_q   <= hit_d;
                addr_q   <= addr_d;
                blank1_q <= blank;
                off1_q   <= off_d;
                bg1_q    <= bg_rgb;
                hit2_q   <= hit1_q;
                blank2_q <= blank1_q;
                off2_q   <= off1_q;
                bg2_q    <= bg1_q;
                rgb_q    <= rgb_d;
                v1_q     <= 1'b1;
                v2_q     <= v1_q;
            end
        end
    end

    assign rom_addr   = addr_q;
    assign rom_rd     = pix_en;
    assign Red        = rgb_q[23:16];
    assign Green      = rgb_q[15:8];
    assign Blue       = rgb_q[7:0];
    assign out_valid  = out_valid_q;
    assign collision  = coll_q;
    assign coll_valid = coll_valid_q;

endmodule
